ctrl_pkt_gen: RTL and testbench

//  Transmit end of the RMT control path. Turns table-write commands into 2-beat control AXIS packets
//  and drives them into the c_s_axis_* input of stage 0. Beat 0 is the header; beat 1 is the entry payload.
//  No tready exists on this path; a minimum idle gap between packets paces the stage receivers.

---
 rtl/rmt_ctrl_defs.sv | 27 ++
 rtl/keep_popcount.sv | 35 +++
 rtl/ctrl_pkt_gen.sv | 157 +++++++++++++++
 tb/tb_ctrl_pkt_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_ctrl_defs.sv
// Shared constants for the RMT control path: module ids, header layout, default control port.
package rmt_ctrl_defs;

    // Target module ids carried in the header id byte
    localparam logic [2:0] MOD_KEY_EXTRACT = 3'd0;
    localparam logic [2:0] MOD_KEY_MASK    = 3'd1;
    localparam logic [2:0] MOD_LOOKUP_CAM  = 3'd2;
    localparam logic [2:0] MOD_LOOKUP_RAM  = 3'd3;
    localparam logic [2:0] MOD_ACTION_RAM  = 3'd4;

    // UDP destination port that marks a control packet
    localparam logic [15:0] CTRL_UDP_PORT_DEFAULT = 16'hf1f2;

    // Header byte offsets (byte n = tdata[8n+7:8n]) and fixed header length
    localparam int unsigned HDR_PORT_BYTE = 36;
    localparam int unsigned HDR_ID_BYTE   = 46;
    localparam int unsigned HDR_ADDR_BYTE = 47;
    localparam int unsigned HDR_BASE_LEN  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PLD  = 2'd2,
        ST_GAP  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/keep_popcount.sv
// Registered packet length: BASE plus the number of set lanes in a keep vector.
// Holds the value for exactly one cycle after load, zero otherwise.
module keep_popcount #(
    parameter int unsigned KW   = 64,
    parameter int unsigned BASE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [KW-1:0] keep,
    output logic [15:0]   len_q
);

    logic [15:0] pop_c;

    // Count set lanes in the keep vector
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(KW); i++) begin
            pop_c = pop_c + 16'(keep[i]);
        end
    end

    // Capture length on load, clear on every other cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (load) begin
            len_q <= 16'(BASE) + pop_c;
        end else begin
            len_q <= '0;
        end
    end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Control packet generator: turns table-write commands into 2-beat AXIS
// control packets (header + entry payload) with a minimum idle gap after each.
module ctrl_pkt_gen
    import rmt_ctrl_defs::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_STAGES           = 5,
    parameter logic [15:0] CTRL_UDP_PORT        = CTRL_UDP_PORT_DEFAULT,
    parameter int unsigned GAP_CYCLES           = 4
) (
    input  logic                                axis_clk,
    input  logic                                aresetn,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [4:0]                          cmd_stage_id,
    input  logic [2:0]                          cmd_module_id,
    input  logic [7:0]                          cmd_addr,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      cmd_data,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    cmd_keep,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
    output logic                                c_m_axis_tvalid,
    output logic                                c_m_axis_tlast,
    output logic [31:0]                         pkt_cnt,
    output logic [15:0]                         err_cnt
);

    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned TW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned GW = 4;

    ctrl_state_e   state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] data_q;
    logic [KW-1:0] keep_q;
    logic [DW-1:0] hdr_c;
    logic [15:0]   len_q;

    logic          ready_d;
    logic          tvalid_d;
    logic          tlast_d;
    logic [DW-1:0] tdata_d;
    logic [KW-1:0] tkeep_d;
    logic [31:0]   pkt_d;
    logic [15:0]   err_d;
    logic          load_c;

    // Header beat assembled straight from the command fields at acceptance
    always_comb begin
        hdr_c = '0;
        hdr_c[8*HDR_PORT_BYTE +: 8]       = CTRL_UDP_PORT[15:8];
        hdr_c[8*(HDR_PORT_BYTE + 1) +: 8] = CTRL_UDP_PORT[7:0];
        hdr_c[8*HDR_ID_BYTE +: 8]         = {cmd_module_id, cmd_stage_id};
        hdr_c[8*HDR_ADDR_BYTE +: 8]       = cmd_addr;
    end

    // Next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        ready_d  = 1'b0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        tkeep_d  = '0;
        pkt_d    = pkt_cnt;
        err_d    = err_cnt;
        load_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    if (32'(cmd_stage_id) < NUM_STAGES) begin
                        state_d  = ST_HDR;
                        load_c   = 1'b1;
                        ready_d  = 1'b0;
                        tvalid_d = 1'b1;
                        tkeep_d  = '1;
                        tdata_d  = hdr_c;
                    end else if (err_cnt != 16'hffff) begin
                        err_d = err_cnt + 16'd1;
                    end
                end
            end
            ST_HDR: begin
                state_d  = ST_PLD;
                tvalid_d = 1'b1;
                tlast_d  = 1'b1;
                tdata_d  = data_q;
                tkeep_d  = keep_q;
                pkt_d    = pkt_cnt + 32'd1;
            end
            ST_PLD: begin
                state_d = ST_GAP;
                gap_d   = '0;
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, output and latch registers; reset truncates any packet in flight
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= ST_IDLE;
            gap_q           <= '0;
            cmd_ready       <= 1'b0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tkeep  <= '0;
            pkt_cnt         <= '0;
            err_cnt         <= '0;
            data_q          <= '0;
            keep_q          <= '0;
        end else begin
            state_q         <= state_d;
            gap_q           <= gap_d;
            cmd_ready       <= ready_d;
            c_m_axis_tvalid <= tvalid_d;
            c_m_axis_tlast  <= tlast_d;
            c_m_axis_tdata  <= tdata_d;
            c_m_axis_tkeep  <= tkeep_d;
            pkt_cnt         <= pkt_d;
            err_cnt         <= err_d;
            if (load_c) begin
                data_q <= cmd_data;
                keep_q <= cmd_keep;
            end
        end
    end

    // Header-beat length, registered alongside the header itself
    keep_popcount #(
        .KW   (KW),
        .BASE (HDR_BASE_LEN)
    ) u_keep_popcount (
        .clk   (axis_clk),
        .rst_n (aresetn),
        .load  (load_c),
        .keep  (cmd_keep),
        .len_q (len_q)
    );

    assign c_m_axis_tuser = TW'(len_q);

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Self-checking bench for ctrl_pkt_gen with a byte-level reference model.
module tb_ctrl_pkt_gen;

    logic         axis_clk = 1'b0;
    logic         aresetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_stage_id;
    logic [2:0]   cmd_module_id;
    logic [7:0]   cmd_addr;
    logic [511:0] cmd_data;
    logic [63:0]  cmd_keep;
    logic [511:0] c_m_axis_tdata;
    logic [127:0] c_m_axis_tuser;
    logic [63:0]  c_m_axis_tkeep;
    logic         c_m_axis_tvalid;
    logic         c_m_axis_tlast;
    logic [31:0]  pkt_cnt;
    logic [15:0]  err_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_pkt = 0;
    logic [15:0] exp_err = 0;

    always #5 axis_clk = ~axis_clk;

    ctrl_pkt_gen dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_stage_id    (cmd_stage_id),
        .cmd_module_id   (cmd_module_id),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .cmd_keep        (cmd_keep),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast),
        .pkt_cnt         (pkt_cnt),
        .err_cnt         (err_cnt)
    );

    // Reference header: a 64-byte array filled per the header layout, then packed
    function automatic logic [511:0] model_hdr(input logic [4:0] st, input logic [2:0] md, input logic [7:0] ad);
        logic [7:0]   b [64];
        logic [511:0] v;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        b[36] = 8'hf1;
        b[37] = 8'hf2;
        b[46] = {md, st};
        b[47] = ad;
        v = '0;
        for (int i = 0; i < 64; i++) v[8*i +: 8] = b[i];
        return v;
    endfunction

    function automatic logic [127:0] model_len(input logic [63:0] k);
        return 128'(64 + $countones(k));
    endfunction

    function automatic logic [63:0] mk_keep(input int n);
        logic [63:0] k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Wait for cmd_ready, present one command for one handshake; returns on the following negedge
    task automatic issue(input logic [4:0] st, input logic [2:0] md, input logic [7:0] ad,
                         input logic [511:0] d, input logic [63:0] k);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge axis_clk);
            w++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_stage_id  = st;
        cmd_module_id = md;
        cmd_addr      = ad;
        cmd_data      = d;
        cmd_keep      = k;
        cmd_valid     = 1'b1;
        @(negedge axis_clk);
        cmd_valid     = 1'b0;
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_stage_id = '0; cmd_module_id = '0; cmd_addr = '0; cmd_data = '0; cmd_keep = '0;
        repeat (3) @(negedge axis_clk);
        tests_run++;
        if (cmd_ready !== 1'b0 || c_m_axis_tvalid !== 1'b0 || c_m_axis_tlast !== 1'b0 ||
            c_m_axis_tdata !== '0 || c_m_axis_tuser !== '0 || c_m_axis_tkeep !== '0 ||
            pkt_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b tvalid=%b pkt=%0d err=%0d required all 0",
                     cmd_ready, c_m_axis_tvalid, pkt_cnt, err_cnt);
        end
        aresetn = 1'b1;
        @(negedge axis_clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        logic [511:0] d = rand_data();
        logic [511:0] hdr;
        issue(5'd2, 3'd3, 8'h15, d, {64{1'b1}});
        hdr = c_m_axis_tdata;
        tests_run++;
        if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b0 || c_m_axis_tkeep !== {64{1'b1}}) begin
            tests_failed++;
            $display("FAIL basic_hdr_ctrl: tvalid=%b tlast=%b tkeep=%h required 1/0/all ones",
                     c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tkeep);
        end
        tests_run++;
        if (hdr[375:368] !== 8'h62 || hdr[383:376] !== 8'h15 || hdr[295:288] !== 8'hf1 || hdr[303:296] !== 8'hf2) begin
            tests_failed++;
            $display("FAIL basic_hdr_bytes: b36=%h b37=%h b46=%h b47=%h required f1 f2 62 15",
                     hdr[295:288], hdr[303:296], hdr[375:368], hdr[383:376]);
        end
        tests_run++;
        if (hdr !== model_hdr(5'd2, 3'd3, 8'h15) || c_m_axis_tuser !== 128'd128) begin
            tests_failed++;
            $display("FAIL basic_hdr_full: tuser=%0d required 128 (header match=%b)",
                     c_m_axis_tuser, hdr === model_hdr(5'd2, 3'd3, 8'h15));
        end
        @(negedge axis_clk);
        exp_pkt++;
        tests_run++;
        if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b1 || c_m_axis_tdata !== d ||
            c_m_axis_tuser !== '0 || pkt_cnt !== exp_pkt) begin
            tests_failed++;
            $display("FAIL basic_pld: tvalid=%b tlast=%b tuser=%0d pkt=%0d required 1/1/0/%0d (data match=%b)",
                     c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tuser, pkt_cnt, exp_pkt, c_m_axis_tdata === d);
        end
        @(negedge axis_clk);
        tests_run++;
        if (c_m_axis_tvalid !== 1'b0 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_gap: tvalid=%b ready=%b required 0/0", c_m_axis_tvalid, cmd_ready);
        end
    endtask

    task automatic test_keep_len();
        logic [511:0] d = rand_data();
        issue(5'd0, 3'd1, 8'h01, d, 64'h0000_0000_0000_00ff);
        tests_run++;
        if (c_m_axis_tuser[15:0] !== 16'd72) begin
            tests_failed++;
            $display("FAIL keep_len: tuser=%0d required 72", c_m_axis_tuser[15:0]);
        end
        @(negedge axis_clk);
        exp_pkt++;
        tests_run++;
        if (c_m_axis_tkeep !== 64'h0000_0000_0000_00ff || c_m_axis_tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL keep_beat1: tkeep=%h tlast=%b required ff/1", c_m_axis_tkeep, c_m_axis_tlast);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] da = rand_data();
        logic [511:0] db = rand_data();
        logic [63:0]  kb = mk_keep(10);
        int cyc = 0, h1 = -1, t1 = -1, h2 = -1, w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin @(negedge axis_clk); w++; end
        cmd_stage_id = 5'd1; cmd_module_id = 3'd0; cmd_addr = 8'h33; cmd_data = da; cmd_keep = {64{1'b1}};
        cmd_valid = 1'b1;
        while (h2 < 0 && cyc < 40) begin
            @(negedge axis_clk);
            cyc++;
            if (c_m_axis_tvalid && !c_m_axis_tlast) begin
                if (h1 < 0) begin
                    h1 = cyc;
                    cmd_stage_id = 5'd4; cmd_module_id = 3'd4; cmd_addr = 8'hc3; cmd_data = db; cmd_keep = kb;
                end else begin
                    h2 = cyc;
                    cmd_valid = 1'b0;
                    tests_run++;
                    if (c_m_axis_tdata !== model_hdr(5'd4, 3'd4, 8'hc3) || c_m_axis_tuser !== model_len(kb)) begin
                        tests_failed++;
                        $display("FAIL b2b_hdr2: tuser=%0d required %0d (header match=%b)", c_m_axis_tuser,
                                 model_len(kb), c_m_axis_tdata === model_hdr(5'd4, 3'd4, 8'hc3));
                    end
                end
            end
            if (c_m_axis_tvalid && c_m_axis_tlast && t1 < 0) begin
                t1 = cyc;
                tests_run++;
                if (c_m_axis_tdata !== da) begin
                    tests_failed++;
                    $display("FAIL b2b_pld1: payload differs from first command");
                end
            end
            if (h1 >= 0 && h2 < 0 && (t1 < 0 || cyc < t1 + 5) && cmd_ready !== 1'b0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL b2b_ready_low: cycle %0d cmd_ready=%b required 0", cyc, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (h2 < 0 || t1 < 0 || h2 - t1 != 6) begin
            tests_failed++;
            $display("FAIL b2b_spacing: hdr2-tlast1=%0d required 6 (h1=%0d t1=%0d h2=%0d)", h2 - t1, h1, t1, h2);
        end
        @(negedge axis_clk);
        exp_pkt += 2;
        tests_run++;
        if (c_m_axis_tlast !== 1'b1 || c_m_axis_tdata !== db || c_m_axis_tkeep !== kb || pkt_cnt !== exp_pkt) begin
            tests_failed++;
            $display("FAIL b2b_pld2: tlast=%b tkeep=%h pkt=%0d required 1/%h/%0d", c_m_axis_tlast,
                     c_m_axis_tkeep, pkt_cnt, kb, exp_pkt);
        end
    endtask

    task automatic test_bad_stage();
        issue(5'd7, 3'd2, 8'h44, rand_data(), {64{1'b1}});
        exp_err++;
        tests_run++;
        if (c_m_axis_tvalid !== 1'b0 || cmd_ready !== 1'b1 || err_cnt !== exp_err) begin
            tests_failed++;
            $display("FAIL bad_stage: tvalid=%b ready=%b err=%0d required 0/1/%0d",
                     c_m_axis_tvalid, cmd_ready, err_cnt, exp_err);
        end
        @(negedge axis_clk);
        tests_run++;
        if (c_m_axis_tvalid !== 1'b0 || pkt_cnt !== exp_pkt) begin
            tests_failed++;
            $display("FAIL bad_stage_quiet: tvalid=%b pkt=%0d required 0/%0d", c_m_axis_tvalid, pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [4:0]   st = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(5, 31)) : 5'($urandom_range(0, 4));
            logic [2:0]   md = 3'($urandom_range(0, 4));
            logic [7:0]   ad = 8'($urandom);
            logic [511:0] d  = rand_data();
            logic [63:0]  k  = mk_keep($urandom_range(1, 64));
            repeat ($urandom_range(0, 3)) @(negedge axis_clk);
            issue(st, md, ad, d, k);
            if (st < 5) begin
                tests_run++;
                if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b0 || c_m_axis_tdata !== model_hdr(st, md, ad) ||
                    c_m_axis_tuser !== model_len(k) || c_m_axis_tkeep !== {64{1'b1}}) begin
                    tests_failed++;
                    $display("FAIL rand_hdr[%0d]: st=%0d tuser=%0d required %0d tvalid=%b tlast=%b",
                             n, st, c_m_axis_tuser, model_len(k), c_m_axis_tvalid, c_m_axis_tlast);
                end
                @(negedge axis_clk);
                exp_pkt++;
                tests_run++;
                if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b1 || c_m_axis_tdata !== d ||
                    c_m_axis_tkeep !== k || c_m_axis_tuser !== '0 || pkt_cnt !== exp_pkt) begin
                    tests_failed++;
                    $display("FAIL rand_pld[%0d]: tkeep=%h required %h pkt=%0d required %0d",
                             n, c_m_axis_tkeep, k, pkt_cnt, exp_pkt);
                end
            end else begin
                if (exp_err != 16'hffff) exp_err++;
                tests_run++;
                if (c_m_axis_tvalid !== 1'b0 || cmd_ready !== 1'b1 || err_cnt !== exp_err) begin
                    tests_failed++;
                    $display("FAIL rand_drop[%0d]: tvalid=%b ready=%b err=%0d required 0/1/%0d",
                             n, c_m_axis_tvalid, cmd_ready, err_cnt, exp_err);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] d = rand_data();
        issue(5'd3, 3'd2, 8'h77, rand_data(), {64{1'b1}});
        tests_run++;
        if (c_m_axis_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_hdr: tvalid=%b required 1", c_m_axis_tvalid);
        end
        aresetn = 1'b0;
        #1;
        exp_pkt = 0;
        exp_err = 0;
        tests_run++;
        if (c_m_axis_tvalid !== 1'b0 || c_m_axis_tdata !== '0 || c_m_axis_tuser !== '0 ||
            cmd_ready !== 1'b0 || pkt_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_drop: tvalid=%b ready=%b pkt=%0d err=%0d required all 0",
                     c_m_axis_tvalid, cmd_ready, pkt_cnt, err_cnt);
        end
        @(negedge axis_clk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge axis_clk);
            tests_run++;
            if (c_m_axis_tvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_no_resume: tvalid=%b required 0", c_m_axis_tvalid);
            end
        end
        issue(5'd4, 3'd1, 8'h5a, d, mk_keep(33));
        tests_run++;
        if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b0 || c_m_axis_tdata !== model_hdr(5'd4, 3'd1, 8'h5a) ||
            c_m_axis_tuser !== 128'd97) begin
            tests_failed++;
            $display("FAIL rst_mid_clean_hdr: tuser=%0d required 97 tvalid=%b", c_m_axis_tuser, c_m_axis_tvalid);
        end
        @(negedge axis_clk);
        exp_pkt++;
        tests_run++;
        if (c_m_axis_tlast !== 1'b1 || c_m_axis_tdata !== d || pkt_cnt !== exp_pkt) begin
            tests_failed++;
            $display("FAIL rst_mid_clean_pld: tlast=%b pkt=%0d required 1/%0d", c_m_axis_tlast, pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_wrap();
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin @(negedge axis_clk); w++; end
        force dut.pkt_cnt = 32'hffff_ffff;
        #1;
        release dut.pkt_cnt;
        issue(5'd0, 3'd0, 8'h00, rand_data(), {64{1'b1}});
        @(negedge axis_clk);
        exp_pkt = 32'd0;
        tests_run++;
        if (pkt_cnt !== exp_pkt) begin
            tests_failed++;
            $display("FAIL pkt_wrap: pkt_cnt=%h required 00000000", pkt_cnt);
        end
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin @(negedge axis_clk); w++; end
        force dut.err_cnt = 16'hffff;
        #1;
        release dut.err_cnt;
        issue(5'd9, 3'd0, 8'h00, rand_data(), {64{1'b1}});
        tests_run++;
        if (err_cnt !== 16'hffff || c_m_axis_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_saturate: err_cnt=%h tvalid=%b required ffff/0", err_cnt, c_m_axis_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_keep_len();
        test_back_to_back();
        test_bad_stage();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
